shootout_score_tracker: RTL and testbench



---
 rtl/shootout_score_tracker.sv | 163 ++++++++++++++++
 tb/tb_shootout_score_tracker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/shootout_score_tracker.sv
// Penalty-shootout score tracker: regulation kicks with early decision, optional
// sudden-death pairs, and a packed score byte for the remote display board.
module shootout_score_tracker #(
  parameter int ROUNDS    = 5,
  parameter int SCORE_W   = 4,
  parameter bit SD_ENABLE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               kick_valid,
  input  logic               kick_side,
  input  logic               kick_goal,
  output logic               expected_side,
  output logic [SCORE_W-1:0] score_player,
  output logic [SCORE_W-1:0] score_enemy,
  output logic [SCORE_W-1:0] kicks_player,
  output logic [SCORE_W-1:0] kicks_enemy,
  output logic               sudden_death,
  output logic               match_end,
  output logic               match_result,
  output logic               match_draw,
  output logic               kick_err,
  output logic [7:0]         tx_data
);

  typedef enum logic [1:0] {IDLE, REG, SD, DONE} state_e;

  localparam logic [SCORE_W-1:0] ROUNDS_L = SCORE_W'(ROUNDS);
  localparam logic [SCORE_W-1:0] CNT_MAX  = '1;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == CNT_MAX) ? v : v + SCORE_W'(1);
  endfunction

  state_e               state_q, state_d;
  logic                 side_q, side_d;
  logic [SCORE_W-1:0]   sp_q, sp_d, se_q, se_d;
  logic [SCORE_W-1:0]   kp_q, kp_d, ke_q, ke_d;
  logic                 sd_q, sd_d, end_q, end_d;
  logic                 win_q, win_d, draw_q, draw_d;
  logic                 err_q, err_d;
  logic [7:0]           tx_q, tx_d;
  // Best final score each side can still reach if it scores every remaining kick.
  logic [SCORE_W:0]     reach_p, reach_e;

  // NOTE: every variable gets its default at the top of the block so no path
  // leaves one unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    side_d  = side_q;
    sp_d    = sp_q;
    se_d    = se_q;
    kp_d    = kp_q;
    ke_d    = ke_q;
    sd_d    = sd_q;
    end_d   = end_q;
    win_d   = win_q;
    draw_d  = draw_q;
    err_d   = 1'b0;
    reach_p = '0;
    reach_e = '0;

    if (abort || start) begin
      // abort outranks start; any kick in the same cycle is dropped silently
      state_d = abort ? IDLE : REG;
      side_d  = 1'b0;
      sp_d    = '0;
      se_d    = '0;
      kp_d    = '0;
      ke_d    = '0;
      sd_d    = 1'b0;
      end_d   = 1'b0;
      win_d   = 1'b0;
      draw_d  = 1'b0;
    end else if (kick_valid && (state_q == REG || state_q == SD)) begin
      if (kick_side != side_q) begin
        err_d = 1'b1;
      end else begin
        side_d = ~side_q;
        if (kick_side) begin
          ke_d = sat_inc(ke_q);
          if (kick_goal) se_d = sat_inc(se_q);
        end else begin
          kp_d = sat_inc(kp_q);
          if (kick_goal) sp_d = sat_inc(sp_q);
        end

        if (state_q == REG) begin
          reach_p = {1'b0, sp_d} + {1'b0, ROUNDS_L - kp_d};
          reach_e = {1'b0, se_d} + {1'b0, ROUNDS_L - ke_d};
          if (reach_p < {1'b0, se_d} || reach_e < {1'b0, sp_d}) begin
            state_d = DONE;
            end_d   = 1'b1;
            win_d   = (sp_d > se_d);
          end else if (kp_d == ROUNDS_L && ke_d == ROUNDS_L) begin
            // Undecided after full regulation means the scores are level.
            if (SD_ENABLE) begin
              state_d = SD;
              sd_d    = 1'b1;
            end else begin
              state_d = DONE;
              end_d   = 1'b1;
              draw_d  = 1'b1;
            end
          end
        end else if (kick_side && (sp_d != se_d)) begin
          state_d = DONE;
          end_d   = 1'b1;
          win_d   = (sp_d > se_d);
        end
      end
    end

    tx_d = {end_d, sd_d, sp_d[2:0], se_d[2:0]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      side_q  <= 1'b0;
      sp_q    <= '0;
      se_q    <= '0;
      kp_q    <= '0;
      ke_q    <= '0;
      sd_q    <= 1'b0;
      end_q   <= 1'b0;
      win_q   <= 1'b0;
      draw_q  <= 1'b0;
      err_q   <= 1'b0;
      tx_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      side_q  <= side_d;
      sp_q    <= sp_d;
      se_q    <= se_d;
      kp_q    <= kp_d;
      ke_q    <= ke_d;
      sd_q    <= sd_d;
      end_q   <= end_d;
      win_q   <= win_d;
      draw_q  <= draw_d;
      err_q   <= err_d;
      tx_q    <= tx_d;
    end
  end

  assign expected_side = side_q;
  assign score_player  = sp_q;
  assign score_enemy   = se_q;
  assign kicks_player  = kp_q;
  assign kicks_enemy   = ke_q;
  assign sudden_death  = sd_q;
  assign match_end     = end_q;
  assign match_result  = win_q;
  assign match_draw    = draw_q;
  assign kick_err      = err_q;
  assign tx_data       = tx_q;

endmodule

// File: tb/tb_shootout_score_tracker.sv
// Scoreboard bench for shootout_score_tracker: instance 0 runs with sudden death,
// instance 1 without; both see the same stimulus.
module tb_shootout_score_tracker;

  logic clk = 1'b0;
  logic rst, start, abort, kick_valid, kick_side, kick_goal;

  logic       es_o [2];
  logic [3:0] sp_o [2];
  logic [3:0] se_o [2];
  logic [3:0] kp_o [2];
  logic [3:0] ke_o [2];
  logic       sd_o [2];
  logic       me_o [2];
  logic       mr_o [2];
  logic       md_o [2];
  logic       err_o[2];
  logic [7:0] tx_o [2];

  always #5 clk = ~clk;

  shootout_score_tracker #(.ROUNDS(5), .SCORE_W(4), .SD_ENABLE(1'b1)) u_sd (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .kick_valid(kick_valid), .kick_side(kick_side), .kick_goal(kick_goal),
    .expected_side(es_o[0]), .score_player(sp_o[0]), .score_enemy(se_o[0]),
    .kicks_player(kp_o[0]), .kicks_enemy(ke_o[0]), .sudden_death(sd_o[0]),
    .match_end(me_o[0]), .match_result(mr_o[0]), .match_draw(md_o[0]),
    .kick_err(err_o[0]), .tx_data(tx_o[0])
  );

  shootout_score_tracker #(.ROUNDS(5), .SCORE_W(4), .SD_ENABLE(1'b0)) u_draw (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .kick_valid(kick_valid), .kick_side(kick_side), .kick_goal(kick_goal),
    .expected_side(es_o[1]), .score_player(sp_o[1]), .score_enemy(se_o[1]),
    .kicks_player(kp_o[1]), .kicks_enemy(ke_o[1]), .sudden_death(sd_o[1]),
    .match_end(me_o[1]), .match_result(mr_o[1]), .match_draw(md_o[1]),
    .kick_err(err_o[1]), .tx_data(tx_o[1])
  );

  typedef struct {
    int         dut;
    logic [3:0] sp, se, kp, ke;
    logic       es, sd, me, mr, md, err;
  } exp_t;

  exp_t e;
  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic clr_exp();
    e.sp = '0; e.se = '0; e.kp = '0; e.ke = '0;
    e.es = 1'b0; e.sd = 1'b0; e.me = 1'b0; e.mr = 1'b0; e.md = 1'b0; e.err = 1'b0;
  endtask

  task automatic compare(input string tag);
    exp_t x;
    int   d;
    x = sb_q.pop_front();
    d = x.dut;
    check({tag, ".sp"},  32'(sp_o[d]),  32'(x.sp));
    check({tag, ".se"},  32'(se_o[d]),  32'(x.se));
    check({tag, ".kp"},  32'(kp_o[d]),  32'(x.kp));
    check({tag, ".ke"},  32'(ke_o[d]),  32'(x.ke));
    check({tag, ".es"},  32'(es_o[d]),  32'(x.es));
    check({tag, ".sd"},  32'(sd_o[d]),  32'(x.sd));
    check({tag, ".end"}, 32'(me_o[d]),  32'(x.me));
    check({tag, ".res"}, 32'(mr_o[d]),  32'(x.mr));
    check({tag, ".drw"}, 32'(md_o[d]),  32'(x.md));
    check({tag, ".err"}, 32'(err_o[d]), 32'(x.err));
    check({tag, ".tx"},  32'(tx_o[d]),  32'({x.me, x.sd, x.sp[2:0], x.se[2:0]}));
  endtask

  // Drive one cycle of inputs at a negedge, then compare at the following negedge.
  task automatic step(input string tag, input logic vld, input logic side, input logic goal,
                      input logic st, input logic ab, input logic rs);
    sb_q.push_back(e);
    kick_valid = vld; kick_side = side; kick_goal = goal;
    start = st; abort = ab; rst = rs;
    @(negedge clk);
    kick_valid = 1'b0; kick_side = 1'b0; kick_goal = 1'b0;
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    compare(tag);
  endtask

  task automatic start_match(input string tag);
    clr_exp();
    step(tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // All ten regulation kicks scored: level at 5/5, sudden death entered.
  task automatic all_goals(input string tag);
    for (int i = 1; i <= 5; i++) begin
      e.sp = 4'(i); e.kp = 4'(i); e.es = 1'b1;
      step(tag, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      e.se = 4'(i); e.ke = 4'(i); e.es = 1'b0;
      if (i == 5) e.sd = 1'b1;
      step(tag, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    kick_valid = 1'b0; kick_side = 1'b0; kick_goal = 1'b0;
    e.dut = 0;
    clr_exp();
    repeat (2) @(negedge clk);
    step("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Early decision: player 3/3, enemy 0/3.
    start_match("early_start");
    for (int i = 1; i <= 3; i++) begin
      e.sp = 4'(i); e.kp = 4'(i); e.es = 1'b1;
      step("early_p", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      e.ke = 4'(i); e.es = 1'b0;
      if (i == 3) begin e.me = 1'b1; e.mr = 1'b1; end
      step("early_e", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step("done_kick_ignored", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Regulation tie, then player wins the first sudden-death pair.
    start_match("sd_start");
    all_goals("sd_reg");
    e.sp = 4'd6; e.kp = 4'd6; e.es = 1'b1;
    step("sd_p", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    e.ke = 4'd6; e.es = 1'b0; e.me = 1'b1; e.mr = 1'b1;
    step("sd_e", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Out-of-turn kick right after start.
    start_match("err_start");
    e.err = 1'b1;
    step("err_pulse", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    e.err = 1'b0;
    step("err_clear", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // No sudden death: ten misses end as a draw (second instance).
    e.dut = 1;
    start_match("draw_start");
    for (int i = 1; i <= 5; i++) begin
      e.kp = 4'(i); e.es = 1'b1;
      step("draw_p", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      e.ke = 4'(i); e.es = 1'b0;
      if (i == 5) begin e.me = 1'b1; e.md = 1'b1; end
      step("draw_e", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    e.dut = 0;

    // Restart mid-regulation at 2/1 with a coinciding kick.
    start_match("restart_start");
    e.sp = 4'd1; e.kp = 4'd1; e.es = 1'b1;
    step("restart_p1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    e.se = 4'd1; e.ke = 4'd1; e.es = 1'b0;
    step("restart_e1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    e.sp = 4'd2; e.kp = 4'd2; e.es = 1'b1;
    step("restart_p2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    clr_exp();
    step("restart_kick", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    e.sp = 4'd1; e.kp = 4'd1; e.es = 1'b1;
    step("restart_in_reg", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    clr_exp();
    step("abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("idle_kick_e", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("idle_kick_p", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("abort_over_start", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("abort_idle_kick", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset during sudden death at 6/6.
    start_match("rst_start");
    all_goals("rst_reg");
    e.sp = 4'd6; e.kp = 4'd6; e.es = 1'b1;
    step("rst_sd_p", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    e.se = 4'd6; e.ke = 4'd6; e.es = 1'b0;
    step("rst_sd_e", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    clr_exp();
    step("rst_sd", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("rst_kick_ignored", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Counters saturate at 15 in sudden death without wrapping or ending.
    start_match("sat_start");
    all_goals("sat_reg");
    for (int i = 6; i <= 17; i++) begin
      e.sp = (i > 15) ? 4'd15 : 4'(i); e.kp = e.sp; e.es = 1'b1;
      step("sat_p", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      e.se = e.sp; e.ke = e.sp; e.es = 1'b0;
      step("sat_e", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    e.es = 1'b1;
    step("sat_p_goal", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    e.es = 1'b0;
    step("sat_e_miss", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
